// File: rtl/pipeline_pkg.sv
// Shared definitions for the LEGv8 pipeline.
// Holds the branch-type encodings driven by the decoder, the 4-bit
// condition-code constants used by B.cond (and later by conditional select),
// and the bit positions of each flag inside the packed {N,Z,C,V} register.
package pipeline_pkg;

    // Branch type carried down the pipe from decode
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_B    = 2'b01;
    localparam logic [1:0] BR_COND = 2'b10;
    localparam logic [1:0] BR_CBZ  = 2'b11;

    // B.cond condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010;
    localparam logic [3:0] COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions within the packed {N,Z,C,V} flag vector
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/ex_mem_stage_cond_check.sv
// cond_check: evaluates a 4-bit LEGv8 condition code against an NZCV vector.
// Purely combinational so it can be shared by branch resolution and by the
// conditional-select datapath.
// Ports:
//   cond  - condition field (EQ..NV)
//   nzcv  - flags packed as {N,Z,C,V}
//   true  - 1 when the condition holds
module cond_check
    import pipeline_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       true
);

    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    // One case arm per condition; AL and NV are both unconditionally true
    // in LEGv8, so the default arm covers them.
    always_comb begin
        true = 1'b1;
        case (cond)
            COND_EQ: true = z;
            COND_NE: true = ~z;
            COND_HS: true = c;
            COND_LO: true = ~c;
            COND_MI: true = n;
            COND_PL: true = ~n;
            COND_VS: true = v;
            COND_VC: true = ~v;
            COND_HI: true = c & ~z;
            COND_LS: true = ~(c & ~z);
            COND_GE: true = (n == v);
            COND_LT: true = (n != v);
            COND_GT: true = ~z & (n == v);
            COND_LE: true = ~(~z & (n == v));
            default: true = 1'b1;
        endcase
    end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register, architectural NZCV register and
// branch resolution for the pipelined LEGv8 datapath.
// Ports:
//   clk, reset (async, active-low)
//   ex_*        - EX-stage instruction: valid, ALU result/flags, control bits,
//                 branch type/cond/target, destination and store operand
//   stall/flush - hazard controls; flush dominates stall
//   mem_*       - registered EX/MEM outputs, control bits gated by mem_valid
//   flags_nzcv  - architectural flags {N,Z,C,V}
//   br_taken    - combinational redirect request to fetch
//   br_target   - combinational branch target (pass-through)
module ex_mem_stage
    import pipeline_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ex_valid,
    input  logic [WIDTH-1:0]    alu_result,
    input  logic                alu_negative,
    input  logic                alu_zero,
    input  logic                alu_overflow,
    input  logic                alu_carry,
    input  logic                ex_setflags,
    input  logic [1:0]          ex_br_type,
    input  logic [3:0]          ex_cond,
    input  logic [WIDTH-1:0]    ex_br_target,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_regwrite,
    input  logic                ex_memread,
    input  logic                ex_memwrite,
    input  logic [WIDTH-1:0]    ex_store_data,
    input  logic                stall,
    input  logic                flush,
    output logic                mem_valid,
    output logic [WIDTH-1:0]    mem_result,
    output logic [WIDTH-1:0]    mem_store_data,
    output logic [REG_BITS-1:0] mem_rd,
    output logic                mem_regwrite,
    output logic                mem_memread,
    output logic                mem_memwrite,
    output logic [3:0]          flags_nzcv,
    output logic                br_taken,
    output logic [WIDTH-1:0]    br_target
);

    logic accept;
    logic cc_true;
    logic cond_true;

    assign accept = ex_valid & ~stall & ~flush;

    // Pipeline register. A flush only needs to kill valid and the control
    // bits; the data fields are left holding to save enable fan-out. Control
    // bits are ANDed with ex_valid so a bubble can never write anything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_rd         <= '0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
        end else if (flush) begin
            mem_valid      <= 1'b0;
            mem_regwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_result     <= alu_result;
            mem_store_data <= ex_store_data;
            mem_rd         <= ex_rd;
            mem_regwrite   <= ex_regwrite & ex_valid;
            mem_memread    <= ex_memread  & ex_valid;
            mem_memwrite   <= ex_memwrite & ex_valid;
        end
    end

    // Architectural flags: only an accepted flag-setting instruction may
    // write them, stored exactly in the ALU's {N,Z,C,V} order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_nzcv <= 4'b0000;
        end else if (accept && ex_setflags) begin
            flags_nzcv <= {alu_negative, alu_zero, alu_carry, alu_overflow};
        end
    end

    // Conditional branches look at the stored flags, i.e. results of older
    // instructions, never at the flags of the instruction in EX.
    cond_check u_cond_check (
        .cond (ex_cond),
        .nzcv (flags_nzcv),
        .true (cc_true)
    );

    // Branch resolution. For CBZ the ALU passes the register operand
    // through, so its zero flag tells us whether the register is zero.
    always_comb begin
        cond_true = 1'b0;
        case (ex_br_type)
            BR_B:    cond_true = 1'b1;
            BR_COND: cond_true = cc_true;
            BR_CBZ:  cond_true = alu_zero;
            default: cond_true = 1'b0;
        endcase
    end

    // Gate with reset so fetch is never redirected while the core is held.
    assign br_taken  = accept & cond_true & reset;
    assign br_target = ex_br_target;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Sits directly downstream of the 64-bit ALU in the pipelined LEGv8 datapath.
- Captures the ALU result and flags into the EX/MEM pipeline register.
- Holds the architectural NZCV flag register, updated only by flag-setting instructions (ADDS/SUBS/ANDS).
- Resolves B, B.cond and CBZ, and drives the taken/target signals back to fetch.

Parameters:
- WIDTH, 64, datapath width of result, store data and branch target
- REG_BITS, 5, destination register index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX-stage instruction is real (not a bubble)
- alu_result  in  WIDTH  ALU result
- alu_negative / alu_zero / alu_overflow / alu_carry  in  1 each  ALU flags
- ex_setflags  in  1  instruction writes NZCV
- ex_br_type  in  2  00 none, 01 B, 10 B.cond, 11 CBZ
- ex_cond  in  4  B.cond condition field
- ex_br_target  in  WIDTH  precomputed branch target
- ex_rd  in  REG_BITS  destination register
- ex_regwrite / ex_memread / ex_memwrite  in  1 each  control bits
- ex_store_data  in  WIDTH  store operand
- stall  in  1  hold the stage
- flush  in  1  squash the EX instruction
- mem_valid  out  1  registered valid
- mem_result  out  WIDTH  registered ALU result
- mem_store_data  out  WIDTH  registered store data
- mem_rd  out  REG_BITS  registered destination
- mem_regwrite / mem_memread / mem_memwrite  out  1 each  registered control bits, forced 0 when mem_valid=0
- flags_nzcv  out  4  architectural flags {N,Z,C,V}
- br_taken  out  1  combinational: redirect fetch this cycle
- br_target  out  WIDTH  combinational: equals ex_br_target

Behaviour:
- Reset (reset=0, asynchronous): all mem_* outputs are 0, flags_nzcv=4'b0000, mem_valid=0. br_taken=0 while reset is asserted.
- Let "accept" = ex_valid & !stall & !flush.
- Pipeline register, on each rising edge:
  - If flush: mem_valid<=0 and all mem_* control bits<=0. Data fields are don't-care and are held. Flush wins over stall.
  - Else if stall: all mem_* registers hold.
  - Else: mem_valid<=ex_valid. Fields load from ex_*. Control bits are ANDed with ex_valid.
- Latency: one cycle from EX inputs to mem_* outputs.
- Flags: on an edge with accept & ex_setflags, flags_nzcv<={alu_negative, alu_zero, alu_carry, alu_overflow}. Otherwise flags_nzcv holds. Flags are stored exactly as the ALU supplies them, with no reinterpretation.
- Branch resolution (combinational; uses stored flags_nzcv, i.e. flags from older instructions):
  - br_taken = accept & cond_true.
  - B: cond_true=1.
  - CBZ: cond_true=alu_zero. The ALU passes the register operand in this case.
  - B.cond: cond_true = the ex_cond evaluation below.
  - none: cond_true=0.
- Condition codes: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !(C&!Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V)); 1110 AL 1; 1111 1.
- Flags-setting instruction carrying a branch: flags update at the edge, and the branch uses pre-update flags. The decoder never emits this combination; the block's behaviour is defined for it anyway.
- Reset mid-operation: registers clear immediately, with no dependence on clk. The first edge after deassertion behaves as a normal edge.
- Branch outputs are never registered here. Fetch samples them in the same cycle.

Decomposition:
- Shared package (pipeline_pkg):
  - BR_NONE/BR_B/BR_COND/BR_CBZ encodings
  - 4-bit condition-code constants COND_EQ..COND_NV
  - NZCV bit-position constants
- One natural combinational sub-module: cond_check (inputs: cond[3:0], nzcv[3:0]; output: true). It is reused later by conditional-select instructions.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 with random inputs toggling, then deassert.
  - Required: all mem_* outputs=0, flags_nzcv=0000, br_taken=0 throughout.
  - Required: first accepted instruction appears one edge later.
- SUBS then B.EQ:
  - Stimulus: cycle 1: ex_setflags=1, alu_zero=1, alu_carry=1, others 0. Cycle 2: ex_br_type=10, ex_cond=0000, ex_br_target=64'h100.
  - Required: flags_nzcv=0110 after edge 1; br_taken=1 and br_target=64'h100 in cycle 2.
  - Repeat with ex_cond=0001: required br_taken=0.
- Signed compares:
  - Stimulus: set flags N=1,V=0, then evaluate conds 1010, 1011, 1100, 1101.
  - Required: br_taken = 0, 1, 0, 1.
- Stall:
  - Stimulus: stall=1 with ex_valid=1, ex_setflags=1, alu_result=64'hDEAD, ex_br_type=01.
  - Required: mem_* and flags_nzcv unchanged, br_taken=0.
  - Required: when stall drops, mem_result=64'hDEAD after the next edge.
- Flush and stall+flush:
  - Stimulus: flush=1 (alone, then together with stall=1), ex_regwrite=1, ex_setflags=1.
  - Required: mem_valid=0, mem_regwrite=0, flags unchanged, br_taken=0.
- CBZ and async reset:
  - Stimulus: ex_br_type=11 with alu_zero=1, then with alu_zero=0.
  - Required: br_taken=1, then 0.
  - Stimulus: assert reset between clock edges.
  - Required: mem_valid and flags_nzcv clear immediately, without waiting for an edge.
